cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Request-side controller placed directly upstream of generic_n_way_cache. Accepts single-word reads,
//  probes the cache and returns hit data. On a miss: fetches the word from backing memory, writes it
//  into the cache through the cache write port, then returns it. Keeps saturating hit/miss counters.
// PARAMETERS
//  DATA_WIDTH  8   word width; must equal the cache DATA_WIDTH
//  ADDR_WIDTH  8   address width; must equal the cache ADDR_WIDTH
//  CNT_WIDTH   16  width of each statistics counter
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     reset, synchronous, active-low
//  req_valid       in   1     read request valid
//  req_ready       out  1     controller can accept a request
//  req_addr        in   ADDR  request address
//  resp_valid      out  1     one-cycle pulse: resp_data valid
//  resp_data       out  DATA  read result
//  cache_re        out  1     cache read enable
//  cache_read_addr out  ADDR  cache read address
//  cache_hit       in   1     cache hit, valid the cycle after cache_re
//  cache_out       in   DATA  cache data, valid the cycle after cache_re
//  cache_we        out  1     cache write enable (refill)
//  cache_write_addr out ADDR  refill address
//  cache_in        out  DATA  refill data
//  mem_req_valid   out  1     backing-memory read request
//  mem_req_ready   in   1     memory accepts request
//  mem_req_addr    out  ADDR  memory address
//  mem_resp_valid  in   1     memory data valid (single-cycle)
//  mem_resp_data   in   DATA  memory data
//  hit_count       out  CNT   saturating hit count
//  miss_count      out  CNT   saturating miss count
// BEHAVIOUR
//  - Reset (rst==0 at an edge): state IDLE; every output 0 except req_ready=1 in the following cycle.
//    Counters cleared; in-flight transaction dropped with no resp_valid. Reset wins over every event.
//  - All outputs registered. FSM: IDLE -> LOOKUP -> CHECK -> {RESP | MEM_REQ -> MEM_WAIT -> FILL -> RESP} -> IDLE.
//  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_addr; go to LOOKUP.
//  - LOOKUP: cache_re=1, cache_read_addr=latched addr for exactly one cycle; req_ready=0.
//  - CHECK: sample cache_hit/cache_out. Hit: latch data, hit_count+1, go to RESP.
//    Miss: miss_count+1, go to MEM_REQ.
//  - MEM_REQ: mem_req_valid=1, mem_req_addr=addr; held stable until mem_req_ready; then MEM_WAIT.
//  - MEM_WAIT: wait for mem_resp_valid; latch mem_resp_data; go to FILL. No timeout.
//  - FILL: cache_we=1, cache_write_addr=addr, cache_in=data for one cycle; go to RESP.
//  - RESP: resp_valid=1 and resp_data=data for one cycle; go to IDLE. req_ready returns to 1 next cycle.
//  - Latency from request handshake edge to resp_valid: hit = 3 cycles; miss = 5 + memory wait cycles.
//  - Back-to-back requests: minimum 4 cycles per hit (1 idle cycle between transactions).
//  - mem_resp_valid outside MEM_WAIT is ignored, including a response to a transaction dropped by reset.
//  - Cache-side inputs are ignored outside CHECK.
//  - Counters saturate at {CNT_WIDTH{1'b1}} and never wrap.
//  - cache_re and cache_we are never high in the same cycle.
//  - Outputs not named active in a state are driven 0.
// STRUCTURE
//  - cache_defs.vh (shared with the cache and its benches): FSM state localparams (3-bit encoding),
//    default DATA/ADDR widths.
//  - Sub-module sat_counter #(WIDTH) (inc, clr -> count), instantiated twice.
//  - Everything else stays in this module.
// TESTING (bench instantiates generic_n_way_cache: DATA 8, ADDR 8, WAYS 2, ENTRIES 8; behavioural memory returns data=addr^8'hFF)
//  1. Cold miss: request 8'hAA, memory ready immediately, 2-cycle memory delay.
//     -> one mem request to 8'hAA; cache_we with 8'h55; resp_data=8'h55; miss_count=1.
//  2. Re-read 8'hAA.
//     -> no mem_req_valid; resp_valid 3 cycles after handshake; resp_data=8'h55; hit_count=1.
//  3. Fill both ways of one set (8'h02, 8'h06), then 8'h0A.
//     -> three misses; re-reading 8'h0A hits with 8'hF5.
//  4. mem_req_ready held low 5 cycles.
//     -> mem_req_valid/mem_req_addr stable throughout; req_ready=0; no second request accepted.
//  5. rst low in MEM_WAIT, then memory responds.
//     -> no resp_valid, no cache_we; counters 0; req_ready=1 one cycle after reset release.
//  6. CNT_WIDTH=2, 5 hits to 8'hAA.
//     -> hit_count stays at 2'b11 after the third hit.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: FSM state encoding and default widths.
package cache_refill_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_FILL     = 3'd5,
        ST_RESP     = 3'd6
    } state_e;

    // True when the state owns the request side, i.e. a transaction is in flight.
    function automatic logic state_is_busy(input state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import cache_refill_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Count register: reset/clear to zero, increment until saturated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clr) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + ONE_VAL;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Request-side controller in front of the n-way cache: probes it, refills from backing
// memory on a miss, returns the word, and keeps saturating hit/miss statistics.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  cache_re,
    output logic [ADDR_WIDTH-1:0] cache_read_addr,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_out,
    output logic                  cache_we,
    output logic [ADDR_WIDTH-1:0] cache_write_addr,
    output logic [DATA_WIDTH-1:0] cache_in,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_cache_re;
    logic [ADDR_WIDTH-1:0] r_cache_read_addr;
    logic                  r_cache_we;
    logic [ADDR_WIDTH-1:0] r_cache_write_addr;
    logic [DATA_WIDTH-1:0] r_cache_in;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_req_addr;

    state_e                w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [DATA_WIDTH-1:0] w_data_next;
    logic                  w_hit_inc;
    logic                  w_miss_inc;
    logic                  w_busy;

    assign w_busy = state_is_busy(r_state);

    // Next-state logic; cache and memory inputs are only looked at in their owning state.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready && !w_busy) begin
                    w_state_next = ST_LOOKUP;
                    w_addr_next  = req_addr;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (cache_hit) begin
                    w_data_next  = cache_out;
                    w_hit_inc    = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_miss_inc   = 1'b1;
                    w_state_next = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = ST_MEM_WAIT;
                end else begin
                    w_state_next = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) begin
                    w_data_next  = mem_resp_data;
                    w_state_next = ST_FILL;
                end else begin
                    w_state_next = ST_MEM_WAIT;
                end
            end
            ST_FILL: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs are decoded from the next state so
    // each one is already valid in the cycle its state is entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state            <= ST_IDLE;
            r_addr             <= ADDR_ZERO;
            r_data             <= DATA_ZERO;
            r_req_ready        <= 1'b0;
            r_resp_valid       <= 1'b0;
            r_resp_data        <= DATA_ZERO;
            r_cache_re         <= 1'b0;
            r_cache_read_addr  <= ADDR_ZERO;
            r_cache_we         <= 1'b0;
            r_cache_write_addr <= ADDR_ZERO;
            r_cache_in         <= DATA_ZERO;
            r_mem_req_valid    <= 1'b0;
            r_mem_req_addr     <= ADDR_ZERO;
        end else begin
            r_state            <= w_state_next;
            r_addr             <= w_addr_next;
            r_data             <= w_data_next;
            r_req_ready        <= (w_state_next == ST_IDLE);
            r_cache_re         <= (w_state_next == ST_LOOKUP);
            r_cache_read_addr  <= (w_state_next == ST_LOOKUP) ? w_addr_next : ADDR_ZERO;
            r_mem_req_valid    <= (w_state_next == ST_MEM_REQ);
            r_mem_req_addr     <= (w_state_next == ST_MEM_REQ) ? w_addr_next : ADDR_ZERO;
            r_cache_we         <= (w_state_next == ST_FILL);
            r_cache_write_addr <= (w_state_next == ST_FILL) ? w_addr_next : ADDR_ZERO;
            r_cache_in         <= (w_state_next == ST_FILL) ? w_data_next : DATA_ZERO;
            r_resp_valid       <= (w_state_next == ST_RESP);
            r_resp_data        <= (w_state_next == ST_RESP) ? w_data_next : DATA_ZERO;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_hit_inc),
        .i_clr   (1'b0),
        .o_count (hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_inc),
        .i_clr   (1'b0),
        .o_count (miss_count)
    );

    assign req_ready        = r_req_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_data        = r_resp_data;
    assign cache_re         = r_cache_re;
    assign cache_read_addr  = r_cache_read_addr;
    assign cache_we         = r_cache_we;
    assign cache_write_addr = r_cache_write_addr;
    assign cache_in         = r_cache_in;
    assign mem_req_valid    = r_mem_req_valid;
    assign mem_req_addr     = r_mem_req_addr;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural cache and a backing memory
// returning addr^8'hFF; a second instance with 2-bit counters shares every input.
module tb_cache_refill_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_addr;
    logic       cache_hit;
    logic [7:0] cache_out;
    logic       mem_req_ready;
    logic       mem_resp_valid;
    logic [7:0] mem_resp_data;

    logic        req_ready, resp_valid, cache_re, cache_we, mem_req_valid;
    logic [7:0]  resp_data, cache_read_addr, cache_write_addr, cache_in, mem_req_addr;
    logic [15:0] hit_count, miss_count;

    logic        u2_req_ready, u2_resp_valid, u2_cache_re, u2_cache_we, u2_mem_req_valid;
    logic [7:0]  u2_resp_data, u2_cache_read_addr, u2_cache_write_addr, u2_cache_in, u2_mem_req_addr;
    logic [1:0]  u2_hit_count, u2_miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .cache_re(cache_re),
        .cache_read_addr(cache_read_addr), .cache_hit(cache_hit), .cache_out(cache_out),
        .cache_we(cache_we), .cache_write_addr(cache_write_addr), .cache_in(cache_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_refill_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(u2_req_ready), .req_addr(req_addr),
        .resp_valid(u2_resp_valid), .resp_data(u2_resp_data), .cache_re(u2_cache_re),
        .cache_read_addr(u2_cache_read_addr), .cache_hit(cache_hit), .cache_out(cache_out),
        .cache_we(u2_cache_we), .cache_write_addr(u2_cache_write_addr), .cache_in(u2_cache_in),
        .mem_req_valid(u2_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(u2_mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(u2_hit_count), .miss_count(u2_miss_count)
    );

    // Behavioural cache: result appears the cycle after cache_re; contents survive controller reset.
    logic [7:0]   c_data [256];
    logic [255:0] c_valid = '0;
    always @(posedge clk) begin
        if (cache_re) begin
            cache_hit <= c_valid[cache_read_addr];
            cache_out <= c_data[cache_read_addr];
        end else begin
            cache_hit <= 1'b0;
            cache_out <= 8'h00;
        end
        if (cache_we) begin
            c_valid[cache_write_addr] <= 1'b1;
            c_data[cache_write_addr]  <= cache_in;
        end
    end

    // Backing memory: the response arrives mem_delay cycles after the accepting edge.
    int         mem_delay   = 1;
    int         mem_cnt     = 0;
    int         mem_acc_cnt = 0;
    logic [7:0] mem_addr    = 8'h00;
    always @(posedge clk) begin
        mem_resp_valid <= 1'b0;
        if (mem_cnt != 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= mem_addr ^ 8'hFF;
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            mem_acc_cnt <= mem_acc_cnt + 1;
            mem_addr    <= mem_req_addr;
            if (mem_delay <= 1) begin
                mem_resp_valid <= 1'b1;
                mem_resp_data  <= mem_req_addr ^ 8'hFF;
            end else begin
                mem_cnt <= mem_delay - 1;
            end
        end
    end

    int         resp_cnt = 0;
    int         we_cnt   = 0;
    int         both_cnt = 0;
    logic [7:0] last_we_addr = 8'h00;
    logic [7:0] last_we_data = 8'h00;
    always @(negedge clk) begin
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (cache_we) begin
            we_cnt       <= we_cnt + 1;
            last_we_addr <= cache_write_addr;
            last_we_data <= cache_in;
        end
        if (cache_re && cache_we) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One read: handshake, then count negedges until resp_valid (lat=0 on timeout).
    task automatic issue(input logic [7:0] a, output int lat, output logic [7:0] d);
        int n;
        lat = 0;
        d   = 8'h00;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
                d   = resp_data;
                break;
            end
        end
    endtask

    int         lat, acc0, we0, resp0, n;
    logic [7:0] d;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = 8'h00; mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_outputs", {resp_valid, cache_re, cache_we, mem_req_valid}, 0);
        chk("rst_counts", {hit_count, miss_count}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 1);

        // 1: cold miss on AA, memory data 55 two cycles after acceptance.
        mem_delay = 2; acc0 = mem_acc_cnt; we0 = we_cnt;
        issue(8'hAA, lat, d);
        chk("t1_data", d, 8'h55);
        chk("t1_lat", lat, 7);
        @(negedge clk);
        chk("t1_mem_reqs", mem_acc_cnt - acc0, 1);
        chk("t1_mem_addr", mem_addr, 8'hAA);
        chk("t1_fills", we_cnt - we0, 1);
        chk("t1_fill_addr", last_we_addr, 8'hAA);
        chk("t1_fill_data", last_we_data, 8'h55);
        chk("t1_miss_cnt", miss_count, 1);
        chk("t1_req_ready", req_ready, 1);

        // 2: re-read AA hits with 3-cycle latency and no memory traffic.
        mem_delay = 1; acc0 = mem_acc_cnt;
        issue(8'hAA, lat, d);
        chk("t2_data", d, 8'h55);
        chk("t2_lat", lat, 3);
        chk("t2_hit_cnt", hit_count, 1);
        @(negedge clk);
        chk("t2_mem_reqs", mem_acc_cnt - acc0, 0);

        // 3: three misses into one set, then a hit on the last.
        acc0 = mem_acc_cnt;
        issue(8'h02, lat, d); chk("t3_d02", d, 8'hFD);
        issue(8'h06, lat, d); chk("t3_d06", d, 8'hF9);
        issue(8'h0A, lat, d); chk("t3_d0A", d, 8'hF5);
        chk("t3_miss_cnt", miss_count, 4);
        issue(8'h0A, lat, d);
        chk("t3_hit_data", d, 8'hF5);
        chk("t3_hit_lat", lat, 3);
        chk("t3_hit_cnt", hit_count, 2);
        @(negedge clk);
        chk("t3_mem_reqs", mem_acc_cnt - acc0, 3);

        // 4: memory back-pressure for 5 cycles while another request is offered.
        mem_req_ready = 1'b0; acc0 = mem_acc_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h11;
        @(posedge clk);
        #1 req_addr = 8'h22;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            chk("t4_mem_valid", mem_req_valid, 1);
            chk("t4_mem_addr", mem_req_addr, 8'h11);
            chk("t4_req_ready", req_ready, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1; req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp_valid) begin lat = k; d = resp_data; break; end
        end
        chk("t4_resp_seen", (lat != 0), 1);
        chk("t4_data", d, 8'hEE);
        chk("t4_mem_reqs", mem_acc_cnt - acc0, 1);
        chk("t4_miss_cnt", miss_count, 5);
        chk("t4_hit_cnt", hit_count, 2);

        // 5: reset while waiting on memory; the late response must be ignored.
        mem_delay = 4;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 8'h30;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_req_valid && n < 20);
        chk("t5_mem_valid", mem_req_valid, 1);
        @(posedge clk);
        @(negedge clk);
        resp0 = resp_cnt; we0 = we_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_rst_ready", req_ready, 0);
        chk("t5_rst_outs", {resp_valid, cache_we, mem_req_valid}, 0);
        chk("t5_rst_counts", {hit_count, miss_count}, 0);
        @(negedge clk);
        chk("t5_rel_ready", req_ready, 1);
        repeat (8) @(negedge clk);
        chk("t5_no_resp", resp_cnt - resp0, 0);
        chk("t5_no_fill", we_cnt - we0, 0);
        chk("t5_counts", {hit_count, miss_count}, 0);
        chk("t5_ready_idle", req_ready, 1);

        // 6: five hits on AA; the 2-bit instance saturates at 3.
        for (int i = 1; i <= 5; i++) begin
            issue(8'hAA, lat, d);
            chk("t6_data", d, 8'h55);
            chk("t6_u2_hits", u2_hit_count, (i < 3) ? i : 3);
        end
        chk("t6_hit_cnt", hit_count, 5);
        chk("t6_u2_miss", u2_miss_count, 0);
        chk("re_we_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
